// File: rtl/mux_scan_sequencer_if.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer_if
//   Bundle between the scan sequencer and its environment. The environment
//   (master) requests scans and returns the mux output; the sequencer (slave)
//   drives the mux selects and reports the captured snapshot.
//
//   start   master->slave  scan request, sampled on rising clk
//   d       master->slave  mux output fed back from mux_circuit.d
//   s1, s0  slave->master  registered mux select lines
//   sample  slave->master  4-bit snapshot, sample[n] = d seen with select n
//   valid   slave->master  one-cycle pulse, sample complete and stable
//   busy    slave->master  high from start acceptance until valid deasserts
// -----------------------------------------------------------------------------
interface mux_scan_sequencer_if;
  logic       start;
  logic       d;
  logic       s1;
  logic       s0;
  logic [3:0] sample;
  logic       valid;
  logic       busy;

  modport master (
    output start,
    output d,
    input  s1,
    input  s0,
    input  sample,
    input  valid,
    input  busy
  );

  modport slave (
    input  start,
    input  d,
    output s1,
    output s0,
    output sample,
    output valid,
    output busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// mux_scan_sequencer
//   Turns a combinational 4:1 mux into a scannable 4-channel input port.
//   On an accepted start it steps the selects through channels 0..3, holds
//   each for SETTLE cycles, captures d at the end of each hold, then pulses
//   valid for one cycle.
//
//   Parameters
//     SETTLE  cycles each select is held before d is captured (1..255)
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     mux_scan_sequencer_if.slave (start, d in; s1, s0, sample,
//             valid, busy out)
// -----------------------------------------------------------------------------
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_scan_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  // Wait counter only has to reach SETTLE-1; keep at least one bit so the
  // SETTLE=1 case still elaborates (it then always reads 0 = last count).
  localparam int unsigned       WC_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WC_W-1:0]   WC_LAST = WC_W'(SETTLE - 1);

  state_t          r_state;
  logic [WC_W-1:0] r_wc;
  logic [1:0]      r_ch;
  logic [1:0]      r_sel;
  logic [3:0]      r_sample;
  logic            r_valid;
  logic            r_busy;

  logic            w_settled;
  logic            w_last_ch;

  assign w_settled = (r_wc == WC_LAST);
  assign w_last_ch = (r_ch == 2'd3);

  // NOTE: every register here is state, so it is written with <= only; the
  // async reset clears them all, giving the required immediate output reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wc     <= '0;
      r_ch     <= 2'd0;
      r_sel    <= 2'd0;
      r_sample <= 4'b0000;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_sel   <= 2'd0;
          if (bus.start) begin
            r_state  <= ST_SETTLE;
            r_sample <= 4'b0000;
            r_ch     <= 2'd0;
            r_wc     <= '0;
            r_busy   <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (w_settled) begin
            // d is captured unregistered: the hold time is what makes it
            // stable at this edge.
            r_sample[r_ch] <= bus.d;
            r_wc           <= '0;
            if (w_last_ch) begin
              r_state <= ST_DONE;
              r_sel   <= 2'd0;
              r_ch    <= 2'd0;
              r_valid <= 1'b1;
            end else begin
              r_ch  <= r_ch + 2'd1;
              r_sel <= r_ch + 2'd1;
            end
          end else begin
            r_wc <= r_wc + 1'b1;
          end
        end

        ST_DONE: begin
          // start is deliberately not looked at here; a held start is
          // picked up on the following IDLE edge.
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_sel   <= 2'd0;
        end
      endcase
    end
  end

  assign bus.s1     = r_sel[1];
  assign bus.s0     = r_sel[0];
  assign bus.sample = r_sample;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_sequencer
//   Two sequencers (SETTLE=3 and SETTLE=1), each fed by a mux model
//   d = pattern[{s1,s0}]. Expected snapshots go into per-instance queues when
//   a scan is launched; monitors pop and compare on every valid pulse. Cycle
//   timing of selects, valid and busy is checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_mux_scan_sequencer;

  logic clk;
  logic rst_n;

  mux_scan_sequencer_if bus3 ();
  mux_scan_sequencer_if bus1 ();

  logic [3:0] pat3;
  logic [3:0] pat1;

  assign bus3.d = pat3[{bus3.s1, bus3.s0}];
  assign bus1.d = pat1[{bus1.s1, bus1.s0}];

  mux_scan_sequencer #(.SETTLE(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  mux_scan_sequencer #(.SETTLE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] sb3[$];
  logic [3:0] sb1[$];
  logic [3:0] exp3;
  logic [3:0] exp1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (bus3.valid === 1'b1) begin
      if (sb3.size() == 0) begin
        check("sb3_unexpected_valid", 32'(bus3.valid), 32'd0);
      end else begin
        exp3 = sb3.pop_front();
        check("sb3_sample", 32'(bus3.sample), 32'(exp3));
      end
    end
  end

  always @(negedge clk) begin
    if (bus1.valid === 1'b1) begin
      if (sb1.size() == 0) begin
        check("sb1_unexpected_valid", 32'(bus1.valid), 32'd0);
      end else begin
        exp1 = sb1.pop_front();
        check("sb1_sample", 32'(bus1.sample), 32'(exp1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctl3(input string name, input int sel, input int v,
                            input int b);
    check({name, "_sel"},   32'({bus3.s1, bus3.s0}), 32'(sel));
    check({name, "_valid"}, 32'(bus3.valid), 32'(v));
    check({name, "_busy"},  32'(bus3.busy),  32'(b));
  endtask

  task automatic check_ctl1(input string name, input int sel, input int v,
                            input int b);
    check({name, "_sel"},   32'({bus1.s1, bus1.s0}), 32'(sel));
    check({name, "_valid"}, 32'(bus1.valid), 32'(v));
    check({name, "_busy"},  32'(bus1.busy),  32'(b));
  endtask

  // Bounded wait for a valid pulse on the SETTLE=3 instance.
  task automatic wait_valid3(input string name, input int budget);
    int found;
    found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      tick();
      if (bus3.valid === 1'b1) found = 1;
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    bus3.start = 1'b0;
    bus1.start = 1'b0;
    pat3       = 4'b0000;
    pat1       = 4'b0000;

    // Reset and idle
    repeat (3) tick();
    check_ctl3("reset3", 0, 0, 0);
    check("reset3_sample", 32'(bus3.sample), 32'd0);
    check_ctl1("reset1", 0, 0, 0);
    check("reset1_sample", 32'(bus1.sample), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_ctl3("idle3", 0, 0, 0);
      check("idle3_sample", 32'(bus3.sample), 32'd0);
    end

    // Basic scan, pattern i0..i3 = 1,0,1,0 -> sample 0101
    pat3 = 4'b0101;
    sb3.push_back(4'b0101);
    bus3.start = 1'b1;
    tick();                                   // E0
    bus3.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check_ctl3("basic_hold", k / 3, 0, 1);
      tick();
    end
    check_ctl3("basic_done", 0, 1, 1);        // E0+12
    check("basic_done_sample", 32'(bus3.sample), 32'h5);
    tick();                                   // E0+13
    check_ctl3("basic_idle", 0, 0, 0);
    check("basic_hold_sample", 32'(bus3.sample), 32'h5);

    // Back-to-back scans with start held, pattern 0,1,0,1 -> 1010
    pat3 = 4'b1010;
    sb3.push_back(4'b1010);
    sb3.push_back(4'b1010);
    bus3.start = 1'b1;
    tick();                                   // E0
    repeat (12) tick();                       // E0+12
    check_ctl3("b2b_done1", 0, 1, 1);
    tick();                                   // E0+13, DONE -> IDLE
    check("b2b_gap_busy", 32'(bus3.busy), 32'd0);
    tick();                                   // E0+14, second accept
    check("b2b_restart_busy", 32'(bus3.busy), 32'd1);
    check("b2b_cleared_0", 32'(bus3.sample), 32'd0);
    tick();
    check("b2b_cleared_1", 32'(bus3.sample), 32'd0);
    tick();
    check("b2b_cleared_2", 32'(bus3.sample), 32'd0);
    bus3.start = 1'b0;
    wait_valid3("b2b_second_valid", 20);
    tick();
    check("b2b_end_busy", 32'(bus3.busy), 32'd0);

    // Start ignored while busy, pattern 1,1,0,0 -> 0011
    pat3 = 4'b0011;
    sb3.push_back(4'b0011);
    bus3.start = 1'b1;
    tick();                                   // E0
    bus3.start = 1'b0;
    repeat (4) tick();                        // E0+4
    bus3.start = 1'b1;
    tick();                                   // E0+5, start ignored
    bus3.start = 1'b0;
    check_ctl3("ign_mid", 1, 0, 1);
    repeat (7) tick();                        // E0+12
    check_ctl3("ign_done", 0, 1, 1);
    bus3.start = 1'b1;
    tick();                                   // E0+13, start ignored in DONE
    bus3.start = 1'b0;
    check_ctl3("ign_after", 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("ign_no_restart", 32'(bus3.busy), 32'd0);
    end

    // Mid-scan reset, pattern 0,1,1,0 -> 0110
    pat3 = 4'b0110;
    bus3.start = 1'b1;
    tick();                                   // E0
    bus3.start = 1'b0;
    repeat (7) tick();                        // E0+7
    check("rst_pre_sample", 32'(bus3.sample), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    check_ctl3("rst_async", 0, 0, 0);
    check("rst_async_sample", 32'(bus3.sample), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_ctl3("rst_released", 0, 0, 0);
    sb3.push_back(4'b0110);
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    wait_valid3("rst_fresh_valid", 20);
    tick();

    // SETTLE=1, pattern 1,1,0,1 -> 1011
    pat1 = 4'b1011;
    sb1.push_back(4'b1011);
    bus1.start = 1'b1;
    tick();                                   // E0
    bus1.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_ctl1("s1_step", k, 0, 1);
      tick();
    end
    check_ctl1("s1_done", 0, 1, 1);           // E0+4
    check("s1_done_sample", 32'(bus1.sample), 32'hB);
    tick();
    check_ctl1("s1_idle", 0, 0, 0);

    repeat (3) tick();
    check("sb3_drained", 32'(sb3.size()), 32'd0);
    check("sb1_drained", 32'(sb1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
